// File: rtl/tl_ctrl_arb_pkg.sv
// Shared defaults, TileLink-UL opcodes and channel field bundles for the control-bus arbiter.
package tl_ctrl_arb_pkg;

    localparam int SRC_W_DEF        = 8;
    localparam int OUT_SRC_W_DEF    = 12;
    localparam int MAX_INFLIGHT_DEF = 4;

    localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_A_GET           = 3'd4;
    localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

    // A-channel payload minus source, which is retagged separately.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [30:0] address;
        logic [7:0]  mask;
        logic        corrupt;
    } tl_a_fields_t;

    // D-channel payload minus source, which carries the routing tag.
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
    } tl_d_fields_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/tl_ctrl_arb_inflight_counter.sv
// Outstanding-request counter for one requester; saturates at zero on an unexpected response.
module tl_ctrl_inflight_counter #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic underflow_o
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o      = (cnt_q == CW'(MAX));
    assign empty_o     = (cnt_q == '0);
    assign underflow_o = dec_i && empty_o;

    // Next count: simultaneous inc and dec cancel; never wrap at either end.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tl_control_arbiter.sv
// Two-requester TileLink-UL arbiter in front of the control-bus coupler: round-robin
// with grant lock on A, source-tag routing on D, per-requester in-flight limit.
module tl_control_arbiter
    import tl_ctrl_arb_pkg::*;
#(
    parameter int SRC_W        = SRC_W_DEF,
    parameter int OUT_SRC_W    = OUT_SRC_W_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 auto_in_0_a_valid,
    output logic                 auto_in_0_a_ready,
    input  logic [2:0]           auto_in_0_a_bits_opcode,
    input  logic [2:0]           auto_in_0_a_bits_param,
    input  logic [2:0]           auto_in_0_a_bits_size,
    input  logic [SRC_W-1:0]     auto_in_0_a_bits_source,
    input  logic [30:0]          auto_in_0_a_bits_address,
    input  logic [7:0]           auto_in_0_a_bits_mask,
    input  logic                 auto_in_0_a_bits_corrupt,
    output logic                 auto_in_0_d_valid,
    input  logic                 auto_in_0_d_ready,
    output logic [2:0]           auto_in_0_d_bits_opcode,
    output logic [2:0]           auto_in_0_d_bits_size,
    output logic [SRC_W-1:0]     auto_in_0_d_bits_source,
    input  logic                 auto_in_1_a_valid,
    output logic                 auto_in_1_a_ready,
    input  logic [2:0]           auto_in_1_a_bits_opcode,
    input  logic [2:0]           auto_in_1_a_bits_param,
    input  logic [2:0]           auto_in_1_a_bits_size,
    input  logic [SRC_W-1:0]     auto_in_1_a_bits_source,
    input  logic [30:0]          auto_in_1_a_bits_address,
    input  logic [7:0]           auto_in_1_a_bits_mask,
    input  logic                 auto_in_1_a_bits_corrupt,
    output logic                 auto_in_1_d_valid,
    input  logic                 auto_in_1_d_ready,
    output logic [2:0]           auto_in_1_d_bits_opcode,
    output logic [2:0]           auto_in_1_d_bits_size,
    output logic [SRC_W-1:0]     auto_in_1_d_bits_source,
    output logic                 auto_out_a_valid,
    input  logic                 auto_out_a_ready,
    output logic [2:0]           auto_out_a_bits_opcode,
    output logic [2:0]           auto_out_a_bits_param,
    output logic [1:0]           auto_out_a_bits_size,
    output logic [OUT_SRC_W-1:0] auto_out_a_bits_source,
    output logic [30:0]          auto_out_a_bits_address,
    output logic [7:0]           auto_out_a_bits_mask,
    output logic                 auto_out_a_bits_corrupt,
    input  logic                 auto_out_d_valid,
    output logic                 auto_out_d_ready,
    input  logic [2:0]           auto_out_d_bits_opcode,
    input  logic [1:0]           auto_out_d_bits_size,
    input  logic [OUT_SRC_W-1:0] auto_out_d_bits_source,
    output logic                 err_unexpected_d
);

    arb_state_e   state_q, state_d;
    logic         lock_idx_q, lock_idx_d;
    logic         ptr_q, ptr_d;
    logic         err_q, err_d;

    tl_a_fields_t a_fld [2];
    logic [SRC_W-1:0] a_src [2];
    tl_d_fields_t d_fld;
    logic [1:0]   a_valid, elig, full, empty, underflow, inc, dec, a_ready;
    logic         gnt, gnt_vld, a_fire, d_sel, d_fire;

    assign a_valid  = {auto_in_1_a_valid, auto_in_0_a_valid};
    assign a_src[0] = auto_in_0_a_bits_source;
    assign a_src[1] = auto_in_1_a_bits_source;
    assign a_fld[0] = '{opcode: auto_in_0_a_bits_opcode, param: auto_in_0_a_bits_param,
                        size: auto_in_0_a_bits_size, address: auto_in_0_a_bits_address,
                        mask: auto_in_0_a_bits_mask, corrupt: auto_in_0_a_bits_corrupt};
    assign a_fld[1] = '{opcode: auto_in_1_a_bits_opcode, param: auto_in_1_a_bits_param,
                        size: auto_in_1_a_bits_size, address: auto_in_1_a_bits_address,
                        mask: auto_in_1_a_bits_mask, corrupt: auto_in_1_a_bits_corrupt};

    // Grant selection: a stalled request keeps the bus; otherwise round-robin among eligible.
    always_comb begin
        gnt     = ptr_q;
        gnt_vld = 1'b0;
        if (state_q == ARB_LOCKED) begin
            gnt     = lock_idx_q;
            gnt_vld = a_valid[lock_idx_q];
        end else if (&elig) begin
            gnt     = ptr_q;
            gnt_vld = 1'b1;
        end else if (elig[0]) begin
            gnt     = 1'b0;
            gnt_vld = 1'b1;
        end else if (elig[1]) begin
            gnt     = 1'b1;
            gnt_vld = 1'b1;
        end
    end

    // Handshakes are forced low during reset so nothing fires while downstream is resetting.
    assign auto_out_a_valid        = gnt_vld && !reset;
    assign a_fire                  = auto_out_a_valid && auto_out_a_ready;
    assign auto_out_a_bits_opcode  = a_fld[gnt].opcode;
    assign auto_out_a_bits_param   = a_fld[gnt].param;
    assign auto_out_a_bits_size    = a_fld[gnt].size[1:0];
    assign auto_out_a_bits_source  = OUT_SRC_W'({gnt, a_src[gnt]});
    assign auto_out_a_bits_address = a_fld[gnt].address;
    assign auto_out_a_bits_mask    = a_fld[gnt].mask;
    assign auto_out_a_bits_corrupt = a_fld[gnt].corrupt;
    assign auto_in_0_a_ready       = a_ready[0];
    assign auto_in_1_a_ready       = a_ready[1];

    // D routing: the tag bit just above the requester source picks the destination.
    assign d_sel            = auto_out_d_bits_source[SRC_W];
    assign d_fld            = '{opcode: auto_out_d_bits_opcode, size: auto_out_d_bits_size};
    assign auto_out_d_ready = (d_sel ? auto_in_1_d_ready : auto_in_0_d_ready) && !reset;
    assign d_fire           = auto_out_d_valid && auto_out_d_ready;

    assign auto_in_0_d_valid        = auto_out_d_valid && !d_sel && !reset;
    assign auto_in_1_d_valid        = auto_out_d_valid && d_sel && !reset;
    assign auto_in_0_d_bits_opcode  = d_fld.opcode;
    assign auto_in_1_d_bits_opcode  = d_fld.opcode;
    assign auto_in_0_d_bits_size    = {1'b0, d_fld.size};
    assign auto_in_1_d_bits_size    = {1'b0, d_fld.size};
    assign auto_in_0_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in_1_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];

    for (genvar i = 0; i < 2; i++) begin : g_req
        assign elig[i]    = a_valid[i] && !full[i];
        assign a_ready[i] = auto_out_a_ready && (gnt == 1'(i)) && elig[i] && !reset;
        assign inc[i]     = a_fire && (gnt == 1'(i));
        assign dec[i]     = d_fire && (d_sel == 1'(i));

        tl_ctrl_inflight_counter #(.MAX(MAX_INFLIGHT)) u_cnt (
            .clk_i       (clock),
            .rst_i       (reset),
            .inc_i       (inc[i]),
            .dec_i       (dec[i]),
            .full_o      (full[i]),
            .empty_o     (empty[i]),
            .underflow_o (underflow[i])
        );
    end

    // Next state: lock while the granted request is stalled, rotate priority past each winner.
    always_comb begin
        state_d    = ARB_IDLE;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        err_d      = err_q || (|underflow);
        if (auto_out_a_valid && !auto_out_a_ready) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = gnt;
        end
        if (a_fire) ptr_d = ~gnt;
    end

    // Arbiter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= 1'b0;
            ptr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
        end
    end

    assign err_unexpected_d = err_q;

    // Upper size bit and upper out-source bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{a_fld[0].size[2], a_fld[1].size[2], auto_out_d_bits_source, empty};

endmodule
